// File: rtl/prefix_add_pipe_if.sv
// Purpose: operand/result channel bundle for prefix_add_pipe (valid/ready on both sides).
// Latency: none, this is wiring only.
// Backpressure: carried by in_ready (block to producer) and out_ready (consumer to block).
// Ports: in_valid/in_ready/in_a/in_b/in_cin on the operand side, out_valid/out_ready/
//        out_sum/out_cout on the result side, plus out_zero when PREFIX_ADD_ZERO_EN is defined.
//        WIDTH must match the WIDTH of the attached prefix_add_pipe.
interface prefix_add_pipe_if #(
    parameter int WIDTH = 48
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
`ifdef PREFIX_ADD_ZERO_EN
    logic             out_zero;

    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_zero
    );
    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_zero
    );
`else
    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout
    );
    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout
    );
`endif
endinterface

// File: rtl/prefix_add_pipe.sv
// Purpose: three-stage Kogge-Stone final adder, sum = (a+b+cin) mod 2^WIDTH plus carry-out.
// Latency: three register stages (PG, lower prefix levels, upper prefix levels + sum).
// Backpressure: full valid/ready, combinational ready chain out_ready -> in_ready, no skid.
// Ports: clk, rst (synchronous, active-high), bus (prefix_add_pipe_if.slave).
// Option: define PREFIX_ADD_ZERO_EN to add the registered out_zero flag (out_sum == 0).
module prefix_add_pipe #(
    parameter int WIDTH = 48
) (
    input  logic              clk,
    input  logic              rst,
    prefix_add_pipe_if.slave  bus
);
    // L prefix levels; the lower half is evaluated in S2, the upper half in S3.
    localparam int L = (WIDTH <= 2) ? 1 : $clog2(WIDTH);
    localparam int H = L / 2;

    logic v1, v2, v3;
    logic r1, r2, r3;

    // S1: bit-level generate/propagate with cin folded into g[0].
    logic [WIDTH-1:0] s1_g, s1_p;
    logic             s1_cin;
    // S2: partially combined group terms plus the raw propagate for the sum step.
    logic [WIDTH-1:0] s2_g, s2_p, s2_praw;
    logic             s2_cin;

    logic [WIDTH-1:0] g1_n, p1_n;
    logic [WIDTH-1:0] g2_n, p2_n, t2_g, t2_p;
    logic [WIDTH-1:0] g3_n, p3_n, t3_g, t3_p;
    logic [WIDTH-1:0] carry_n, sum_n;

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    // Ready chain: a stage may load when it is empty or its successor loads.
    assign r3           = !v3 || bus.out_ready;
    assign r2           = !v2 || r3;
    assign r1           = !v1 || r2;
    assign bus.in_ready = r1 && !rst;

    always_comb begin
        p1_n    = bus.in_a ^ bus.in_b;
        g1_n    = bus.in_a & bus.in_b;
        g1_n[0] = (bus.in_a[0] & bus.in_b[0]) | (p1_n[0] & bus.in_cin);
    end

    // Prefix levels 1..H: distance 2^k at loop index k; low indices pass through.
    always_comb begin
        g2_n = s1_g;
        p2_n = s1_p;
        t2_g = '0;
        t2_p = '0;
        for (int k = 0; k < H; k++) begin
            t2_g = g2_n;
            t2_p = p2_n;
            for (int i = 0; i < WIDTH; i++) begin
                if (i >= (1 << k)) begin
                    g2_n[i] = t2_g[i] | (t2_p[i] & t2_g[i-(1<<k)]);
                    p2_n[i] = t2_p[i] & t2_p[i-(1<<k)];
                end
            end
        end
    end

    // Prefix levels H+1..L, after which g3_n[i] is the carry out of bit i.
    always_comb begin
        g3_n = s2_g;
        p3_n = s2_p;
        t3_g = '0;
        t3_p = '0;
        for (int k = H; k < L; k++) begin
            t3_g = g3_n;
            t3_p = p3_n;
            for (int i = 0; i < WIDTH; i++) begin
                if (i >= (1 << k)) begin
                    g3_n[i] = t3_g[i] | (t3_p[i] & t3_g[i-(1<<k)]);
                    p3_n[i] = t3_p[i] & t3_p[i-(1<<k)];
                end
            end
        end
        carry_n = {g3_n[WIDTH-2:0], s2_cin};
        sum_n   = s2_praw ^ carry_n;
    end

    // Valid bits and output registers; data in S1/S2 is left stale when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            v3     <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            if (r1) v1 <= bus.in_valid;
            if (r2) v2 <= v1;
            if (r3) begin
                v3     <= v2;
                sum_q  <= sum_n;
                cout_q <= g3_n[WIDTH-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r1) begin
            s1_g   <= g1_n;
            s1_p   <= p1_n;
            s1_cin <= bus.in_cin;
        end
        if (r2) begin
            s2_g    <= g2_n;
            s2_p    <= p2_n;
            s2_praw <= s1_p;
            s2_cin  <= s1_cin;
        end
    end

    assign bus.out_valid = v3;
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;

`ifdef PREFIX_ADD_ZERO_EN
    logic zero_q;

    always_ff @(posedge clk) begin
        if (rst)     zero_q <= 1'b0;
        else if (r3) zero_q <= ~|sum_n;
    end

    assign bus.out_zero = zero_q;
`endif
endmodule

// File: tb/tb_prefix_add_pipe.sv
module tb_prefix_add_pipe;
    localparam int W = 48;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prefix_add_pipe_if #(.WIDTH(W)) bus ();
    prefix_add_pipe #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int          n_chk  = 0;
    int          n_fail = 0;
    int          n_acc  = 0;
    int          n_res  = 0;
    logic [63:0] exp_q[$];
    logic [63:0] snap;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        logic [W:0] r;
        r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        return {{(63-W){1'b0}}, r};
    endfunction

    function automatic logic [63:0] res();
        return {{(63-W){1'b0}}, bus.out_cout, bus.out_sum};
    endfunction

    // One cycle from a negedge: drive, log accept/transfer before the posedge, step.
    task automatic cyc(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic ordy);
        bus.in_valid  = iv;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_cin    = ci;
        bus.out_ready = ordy;
        #1;
        if (bus.out_valid && bus.out_ready) begin
            n_res++;
            if (exp_q.size() == 0) chk("result_without_input", 64'(bus.out_valid), 64'd0);
            else                   chk("stream_result", res(), exp_q.pop_front());
        end
        if (iv && bus.in_ready) begin
            exp_q.push_back(model(a, b, ci));
            n_acc++;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) cyc(1'b0, '0, '0, 1'b0, 1'b1);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b1;
        bus.in_a      = 48'd1;
        bus.in_b      = 48'd1;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b1;

        // Reset held two cycles with in_valid high.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
            chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
            chk("rst_out", res(), 64'd0);
        end
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        chk("post_rst_out_valid", 64'(bus.out_valid), 64'd0);

        // Full carry ripple then cin-only, with latency check.
        bus.in_valid = 1'b1; bus.in_a = 48'hFFFF_FFFF_FFFF; bus.in_b = 48'd1; bus.in_cin = 1'b0;
        @(negedge clk);
        chk("lat_c1", 64'(bus.out_valid), 64'd0);
        bus.in_a = 48'd0; bus.in_b = 48'd0; bus.in_cin = 1'b1;
        @(negedge clk);
        chk("lat_c2", 64'(bus.out_valid), 64'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("ripple_valid", 64'(bus.out_valid), 64'd1);
        chk("ripple_result", res(), 64'h1_0000_0000_0000);
        @(negedge clk);
        chk("cin_valid", 64'(bus.out_valid), 64'd1);
        chk("cin_result", res(), 64'h0_0000_0000_0001);
        @(negedge clk);
        chk("ripple_empty", 64'(bus.out_valid), 64'd0);

        // Exact cancellation and a nonzero neighbour.
        bus.in_valid = 1'b1; bus.in_a = 48'd5; bus.in_b = 48'hFFFF_FFFF_FFFB; bus.in_cin = 1'b0;
        @(negedge clk);
        bus.in_b = 48'd1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("cancel_result", res(), 64'h1_0000_0000_0000);
`ifdef PREFIX_ADD_ZERO_EN
        chk("cancel_zero", 64'(bus.out_zero), 64'd1);
`endif
        @(negedge clk);
        chk("five_plus_one", res(), 64'd6);
`ifdef PREFIX_ADD_ZERO_EN
        chk("nonzero_flag", 64'(bus.out_zero), 64'd0);
`endif
        @(negedge clk);

        // 100 back-to-back random operands.
        n_res = 0;
        for (int i = 0; i < 100; i++)
            cyc(1'b1, W'({$urandom, $urandom}), W'({$urandom, $urandom}), 1'($urandom), 1'b1);
        drain();
        chk("stream_count", 64'(n_res), 64'd100);

        // Backpressure: five cycles of offered input with the consumer stalled.
        n_acc = 0;
        n_res = 0;
        for (int i = 0; i < 5; i++) cyc(1'b1, W'(1000 * i + 7), W'({$urandom, $urandom}), 1'(i), 1'b0);
        chk("bp_accepted", 64'(n_acc), 64'd3);
        chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
        chk("bp_head", res(), exp_q[0]);
        snap = res();
        cyc(1'b0, '0, '0, 1'b0, 1'b0);
        chk("bp_stable", res(), snap);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("bp_full_release_ready", 64'(bus.in_ready), 64'd1);
        cyc(1'b1, 48'h8000_0000_0000, 48'h8000_0000_0000, 1'b1, 1'b1);
        drain();
        chk("bp_result_count", 64'(n_res), 64'd4);

        // Reset with all three stages occupied.
        for (int i = 0; i < 3; i++) cyc(1'b1, W'(i + 1), W'(i + 2), 1'b0, 1'b1);
        chk("pre_rst_full", 64'(bus.out_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        exp_q.delete();
        rst = 1'b0;
        bus.in_valid = 1'b1; bus.in_a = 48'd5; bus.in_b = 48'd1; bus.in_cin = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("after_rst_c1", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        chk("after_rst_c2", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        chk("after_rst_valid", 64'(bus.out_valid), 64'd1);
        chk("after_rst_result", res(), 64'd7);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/prefix_add_pipe.md
# prefix_add_pipe

Pipelined parallel-prefix (Kogge-Stone) final adder for the fused multiply-add datapath. Accepts the two operand vectors (e.g. the sum/carry rows from the multiplier compression tree) plus a carry-in. Generates bit-level propagate/generate terms and combines them through registered prefix levels built from group carry-propagate cells. Emits the final sum and carry-out under a valid/ready handshake with full backpressure.

## Interface
- `WIDTH`, 48, operand and sum width; legal values are WIDTH ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  input operands present.
- `in_ready`  out  1  block accepts input this cycle.
- `in_a`  in  WIDTH  operand A.
- `in_b`  in  WIDTH  operand B.
- `in_cin`  in  1  carry-in.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts result.
- `out_sum`  out  WIDTH  (A+B+cin) mod 2^WIDTH.
- `out_cout`  out  1  carry-out of bit WIDTH-1.
- `out_zero`  out  1  out_sum == 0; present only with `PREFIX_ADD_ZERO_EN`.

## Operation
- Three register stages, each with its own valid bit v1/v2/v3. `out_valid` = v3.
- S1 (PG generate), registered on accept:
  - p[i] = a[i]^b[i]; g[i] = a[i]&b[i].
  - The carry-in is folded into bit 0: g[0] = a0&b0 | (a0^b0)&cin.
  - The raw p vector and cin are also registered for the sum step.
- Prefix cell, applied between index i and i-d:
  - G = g_hi | (p_hi & g_lo)
  - P = p_hi & p_lo
  - Indices with i < d pass through unchanged.
- Level count L = ceil(log2 WIDTH); level k uses distance d = 2^(k-1).
- S2: levels 1..floor(L/2) computed from S1 registers, result registered.
- S3: levels floor(L/2)+1..L computed from S2 registers, then:
  - carry c[i] = G[i-1] for i ≥ 1; c[0] = cin.
  - sum[i] = p[i] ^ c[i].
  - cout = G[WIDTH-1].
  - sum and cout registered to the outputs.
- Handshake:
  - r3 = !v3 | out_ready
  - r2 = !v2 | r3
  - r1 = !v1 | r2
  - in_ready = r1 & !rst
- Stage k loads when rk is high: its valid takes the upstream valid and its data takes the upstream data.
- Transfer at the input occurs on in_valid & in_ready; at the output on out_valid & out_ready.
- While out_valid & !out_ready, out_sum/out_cout/out_zero are held stable.
- Results leave strictly in acceptance order; no drop, no duplication.
- Data registers of empty stages may hold stale values. Only the valid bits gate visibility.

## Timing
- Reset values: v1=v2=v3=0, out_valid=0, out_sum=0, out_cout=0, out_zero=0. in_ready=0 while rst is high and 1 on the first cycle after.
- Latency: an operand accepted at edge N produces out_valid=1 after edge N+3, given no stall.
- Throughput: one result per cycle with out_ready held high.
- Full pipeline (v1=v2=v3=1) with out_ready=0: in_ready=0. A simultaneous out_ready=1 and in_valid=1 moves all stages and accepts the new input in the same cycle.
- Reset mid-operation: all in-flight results are discarded. out_valid is 0 from the edge where rst is sampled; there is no partial output.
- Wrap-around: the sum is modulo 2^WIDTH. Overflow is visible only through out_cout; the block applies no signed interpretation.
- The combinational ready chain is a single path from out_ready to in_ready; there is no skid buffer.

## Configuration
- `PREFIX_ADD_ZERO_EN` defined:
  - S3 also registers out_zero = ~|sum, aligned with out_sum, reset to 0.
  - The FMA normalizer uses it to detect exact cancellation.
- Not defined: the out_zero port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset: rst=1 for 2 cycles with in_valid=1 -> out_valid=0, out_sum=0, in_ready=0 during reset, in_ready=1 on the cycle after.
- Full carry ripple: WIDTH=48, a=48'hFFFF_FFFF_FFFF, b=1, cin=0 -> 3 cycles later out_sum=0, out_cout=1. Then a=0, b=0, cin=1 -> out_sum=1, out_cout=0.
- Streaming: 100 back-to-back random (a,b,cin) with out_ready=1 -> one result per cycle after 3-cycle latency, in order, each equal to a+b+cin.
- Backpressure: stream with out_ready=0 for 5 cycles -> exactly 3 results held, in_ready=0 after fill, output stable. On release, all results arrive in order with none lost.
- Reset mid-stream: assert rst with v1..v3 all set -> out_valid=0 after that edge. The next accepted operand appears after exactly 3 cycles.
- Zero flag (macro on): a=5, b=48'hFFFF_FFFF_FFFB, cin=0 -> out_sum=0, out_cout=1, out_zero=1. a=5, b=1 -> out_zero=0.
